kf76489_bus_fifo_control: RTL

Parametrised successor to the KF76489 bus control logic. It captures CPU writes (CE_N/WE_N strobe) into a write FIFO and drives a READY handshake. Queued bytes drain at a fixed chip-timing interval through a latch/data decoder. The decoder implements the full SN76489 latch/data protocol, including data-byte writes to attenuation and noise registers. It feeds the tone/noise register file through a single registered write port.

---
 rtl/kf76489_bus_fifo_control.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/kf76489_bus_fifo_control.sv
// KF76489 bus front end: captures CPU write strobes into a small FIFO,
// then drains the queued bytes at a fixed chip-timing interval through the
// SN76489 latch/data decoder into a single registered register-file write port.
module kf76489_bus_fifo_control #(
    parameter int FIFO_DEPTH     = 4,
    parameter int DRAIN_INTERVAL = 32,
    parameter int CNT_W          = $clog2(DRAIN_INTERVAL)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       CE_N,
    input  logic       WE_N,
    input  logic [7:0] D_IN,
    input  logic       overflow_clear,
    output logic       READY,
    output logic       overflow,
    output logic       write_en,
    output logic [2:0] write_reg,
    output logic       write_part,
    output logic [5:0] write_value
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 prev_we;
    logic [7:0]           d_q;
    logic                 commit;
    logic [7:0]           fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [COUNT_W-1:0]   count;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 drop;
    logic                 issue;
    logic [CNT_W-1:0]     drain_cnt;
    logic [2:0]           latched_reg;
    logic [7:0]           head;

    assign full   = (count == COUNT_W'(FIFO_DEPTH));
    assign empty  = (count == '0);
    assign commit = ~prev_we & WE_N;
    assign push   = commit & (~full | pop);
    assign drop   = commit & full & ~pop;
    assign head   = fifo_mem[rd_ptr];

    // Track the enabled write strobe and sample the data bus so the byte is
    // available in the cycle where the rising WE_N edge is detected.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_we <= 1'b1;
            d_q     <= 8'h00;
        end else begin
            prev_we <= CE_N ? 1'b1 : WE_N;
            d_q     <= D_IN;
        end
    end

    // FIFO storage; contents are don't-care while the occupancy count is zero.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= d_q;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count alone.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // READY follows the registered count one clock later; overflow is sticky
    // and a fresh drop wins over a simultaneous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            READY    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            READY <= ~full;
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Drain FSM next state. The last WAIT cycle pops directly into ISSUE when
    // a backlog exists, so back-to-back pulses land exactly DRAIN_INTERVAL apart.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!empty) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (drain_cnt == '0) state_next = empty ? IDLE : ISSUE;
            default: state_next = IDLE;
        endcase
    end

    // Drain FSM outputs: pop the FIFO head when a new write may start, strobe in ISSUE.
    always_comb begin
        pop   = 1'b0;
        issue = 1'b0;
        case (state)
            IDLE:    pop   = ~empty;
            ISSUE:   issue = 1'b1;
            WAIT:    pop   = ~empty & (drain_cnt == '0);
            default: pop   = 1'b0;
        endcase
    end

    assign write_en = issue;

    // Interval counter: loaded on ISSUE, counts down through WAIT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drain_cnt <= '0;
        end else if (state == ISSUE) begin
            drain_cnt <= CNT_W'(DRAIN_INTERVAL - 2);
        end else if (state == WAIT && drain_cnt != '0) begin
            drain_cnt <= drain_cnt - 1'b1;
        end
    end

    // Decode the popped byte so the write port is valid during ISSUE and then
    // holds its value; frequency registers (0,2,4) take 6-bit data bytes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            latched_reg <= 3'd0;
            write_reg   <= 3'd0;
            write_part  <= 1'b0;
            write_value <= 6'd0;
        end else if (pop) begin
            if (head[7]) begin
                latched_reg <= head[6:4];
                write_reg   <= head[6:4];
                write_part  <= 1'b0;
                write_value <= {2'b00, head[3:0]};
            end else if (latched_reg[0] == 1'b0 && latched_reg != 3'd6) begin
                write_reg   <= latched_reg;
                write_part  <= 1'b1;
                write_value <= head[5:0];
            end else begin
                write_reg   <= latched_reg;
                write_part  <= 1'b0;
                write_value <= {2'b00, head[3:0]};
            end
        end
    end

endmodule
